// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter funnelling producer results onto a single registered CDB
// Each producer owns one holding slot; a granted slot may reload in the same cycle.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int Q_WIDTH    = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*Q_WIDTH-1:0]    req_rob,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          cdb_valid,
    output logic [Q_WIDTH-1:0]            cdb_rob,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]    cdb_src,
    output logic [$clog2(NUM_REQ):0]      pending_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_REQ-1:0]    slot_valid_q, slot_valid_d;
    logic [Q_WIDTH-1:0]    slot_rob_q  [NUM_REQ];
    logic [Q_WIDTH-1:0]    slot_rob_d  [NUM_REQ];
    logic [DATA_WIDTH-1:0] slot_data_q [NUM_REQ];
    logic [DATA_WIDTH-1:0] slot_data_d [NUM_REQ];
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [Q_WIDTH-1:0]    cdb_rob_q, cdb_rob_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [PTR_W-1:0]      cdb_src_q, cdb_src_d;

    logic                  active;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      scan_idx;
    logic [CNT_W-1:0]      pend_cnt;

    assign active = rdy_in && !flush_in;

    // Scan upward from rr_ptr; the first valid slot wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (active) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                scan_idx = PTR_W'((int'(rr_ptr_q) + off) % NUM_REQ);
                if (!grant_any && slot_valid_q[scan_idx]) begin
                    grant_any        = 1'b1;
                    grant_idx        = scan_idx;
                    grant[scan_idx]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = active && (!slot_valid_q[i] || grant[i]);
        end
    end

    // Tag 0 handshakes complete but are discarded rather than stored.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_rob_d   = slot_rob_q;
        slot_data_d  = slot_data_q;
        if (rdy_in) begin
            if (flush_in) begin
                slot_valid_d = '0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) begin
                        slot_valid_d[i] = 1'b0;
                    end
                    if (req_valid[i] && req_ready[i] && (req_rob[i*Q_WIDTH +: Q_WIDTH] != '0)) begin
                        slot_valid_d[i] = 1'b1;
                        slot_rob_d[i]   = req_rob[i*Q_WIDTH +: Q_WIDTH];
                        slot_data_d[i]  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (rdy_in) begin
            if (flush_in) begin
                cdb_valid_d = 1'b0;
                rr_ptr_d    = '0;
            end else if (grant_any) begin
                cdb_valid_d = 1'b1;
                cdb_rob_d   = slot_rob_q[grant_idx];
                cdb_data_d  = slot_data_q[grant_idx];
                cdb_src_d   = grant_idx;
                rr_ptr_d    = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_cnt = pend_cnt + CNT_W'(slot_valid_q[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            slot_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_rob_q[i]  <= '0;
                slot_data_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_rob_q[i]  <= slot_rob_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob     = cdb_rob_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_src     = cdb_src_q;
    assign pending_cnt = pend_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic [3:0]  req_valid;
    logic [19:0] req_rob;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;
    logic [2:0]  pending_cnt;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter #(.NUM_REQ(4), .Q_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_rob(req_rob), .req_data(req_data),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
        .cdb_data(cdb_data), .cdb_src(cdb_src), .pending_cnt(pending_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] tag, input logic [31:0] data);
        req_rob[i*5 +: 5]   = tag;
        req_data[i*32 +: 32] = data;
    endtask

    task automatic do_reset();
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        req_valid = '0;
        req_rob   = '0;
        req_data  = '0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        req_valid = '0; req_rob = '0; req_data = '0;
        #2;
        n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", cdb_valid); end
        n_vec++; if (cdb_rob !== 5'd0) begin n_err++; $display("FAIL reset_rob got %0d exp 0", cdb_rob); end
        n_vec++; if (cdb_data !== 32'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", cdb_data); end
        n_vec++; if (cdb_src !== 2'd0) begin n_err++; $display("FAIL reset_src got %0d exp 0", cdb_src); end
        n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL reset_pending got %0d exp 0", pending_cnt); end
        n_vec++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL reset_ready got %b exp 1111", req_ready); end
        tick();
        rst_in = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100; set_req(2, 5'd5, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        n_vec++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL single_pend1 got %0d exp 1", pending_cnt); end
        n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_early got %b exp 0", cdb_valid); end
        tick();
        n_vec++; if (cdb_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", cdb_valid); end
        n_vec++; if (cdb_rob !== 5'd5) begin n_err++; $display("FAIL single_rob got %0d exp 5", cdb_rob); end
        n_vec++; if (cdb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got %h exp deadbeef", cdb_data); end
        n_vec++; if (cdb_src !== 2'd2) begin n_err++; $display("FAIL single_src got %0d exp 2", cdb_src); end
        n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL single_pend0 got %0d exp 0", pending_cnt); end
        tick();
        n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse got %b exp 0", cdb_valid); end
        n_vec++; if (cdb_rob !== 5'd5) begin n_err++; $display("FAIL single_hold got %0d exp 5", cdb_rob); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_rdy;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'(i * 32'h11));
        tick();
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL cont_ready1 got %b exp 0001", req_ready); end
        for (int k = 2; k < 10; k++) begin
            tick();
            exp_rdy = 4'(1 << ((k - 1) % 4));
            n_vec++; if (cdb_valid !== 1'b1) begin n_err++; $display("FAIL cont_valid k=%0d got %b exp 1", k, cdb_valid); end
            n_vec++; if (cdb_src !== 2'((k - 2) % 4)) begin n_err++; $display("FAIL cont_src k=%0d got %0d exp %0d", k, cdb_src, (k - 2) % 4); end
            n_vec++; if (cdb_rob !== 5'((k - 2) % 4 + 1)) begin n_err++; $display("FAIL cont_rob k=%0d got %0d exp %0d", k, cdb_rob, (k - 2) % 4 + 1); end
            n_vec++; if (cdb_data !== 32'(((k - 2) % 4) * 32'h11)) begin n_err++; $display("FAIL cont_data k=%0d got %h", k, cdb_data); end
            n_vec++; if (pending_cnt !== 3'd4) begin n_err++; $display("FAIL cont_pend k=%0d got %0d exp 4", k, pending_cnt); end
            n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL cont_ready k=%0d got %b exp %b", k, req_ready, exp_rdy); end
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'b0010; set_req(1, 5'd1, 32'd100);
        tick();
        set_req(1, 5'd2, 32'd200);
        #1;
        n_vec++; if (req_ready[1] !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b exp 1", req_ready[1]); end
        tick();
        set_req(1, 5'd3, 32'd300);
        n_vec++; if (cdb_rob !== 5'd1 || cdb_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first got rob %0d v %b exp rob 1 v 1", cdb_rob, cdb_valid); end
        n_vec++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL b2b_pend got %0d exp 1", pending_cnt); end
        tick();
        req_valid = '0;
        n_vec++; if (cdb_rob !== 5'd2 || cdb_data !== 32'd200) begin n_err++; $display("FAIL b2b_second got rob %0d data %0d exp 2 200", cdb_rob, cdb_data); end
        tick();
        n_vec++; if (cdb_rob !== 5'd3 || cdb_valid !== 1'b1) begin n_err++; $display("FAIL b2b_third got rob %0d v %b exp 3 1", cdb_rob, cdb_valid); end
        tick();
        n_vec++; if (cdb_valid !== 1'b0 || pending_cnt !== 3'd0) begin n_err++; $display("FAIL b2b_drain got v %b pend %0d exp 0 0", cdb_valid, pending_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b1011;
        set_req(0, 5'd3, 32'd30); set_req(1, 5'd7, 32'd70); set_req(3, 5'd9, 32'd90);
        tick();
        req_valid = '0;
        n_vec++; if (pending_cnt !== 3'd3) begin n_err++; $display("FAIL stall_load got %0d exp 3", pending_cnt); end
        tick();
        n_vec++; if (cdb_src !== 2'd0 || cdb_rob !== 5'd3) begin n_err++; $display("FAIL stall_pre got src %0d rob %0d exp 0 3", cdb_src, cdb_rob); end
        rdy_in = 1'b0;
        req_valid = 4'b0100; set_req(2, 5'd11, 32'd110);
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready got %b exp 0000", req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_rob !== 5'd3) begin n_err++; $display("FAIL stall_frozen k=%0d got v %b src %0d rob %0d", k, cdb_valid, cdb_src, cdb_rob); end
            n_vec++; if (pending_cnt !== 3'd2) begin n_err++; $display("FAIL stall_pend k=%0d got %0d exp 2", k, pending_cnt); end
        end
        rdy_in = 1'b1; req_valid = '0;
        tick();
        n_vec++; if (cdb_src !== 2'd1 || cdb_rob !== 5'd7 || pending_cnt !== 3'd1) begin n_err++; $display("FAIL stall_resume1 got src %0d rob %0d pend %0d exp 1 7 1", cdb_src, cdb_rob, pending_cnt); end
        tick();
        n_vec++; if (cdb_src !== 2'd3 || cdb_rob !== 5'd9 || pending_cnt !== 3'd0) begin n_err++; $display("FAIL stall_resume2 got src %0d rob %0d pend %0d exp 3 9 0", cdb_src, cdb_rob, pending_cnt); end
        tick();
        n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL stall_end got %b exp 0", cdb_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b0111;
        set_req(0, 5'd1, 32'd1); set_req(1, 5'd2, 32'd2); set_req(2, 5'd3, 32'd3);
        tick();
        req_valid = 4'b1000; set_req(3, 5'd4, 32'd4);
        tick();
        n_vec++; if (pending_cnt !== 3'd3 || cdb_src !== 2'd0) begin n_err++; $display("FAIL flush_pre got pend %0d src %0d exp 3 0", pending_cnt, cdb_src); end
        flush_in = 1'b1;
        req_valid = 4'b0001; set_req(0, 5'd12, 32'd12);
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL flush_ready got %b exp 0000", req_ready); end
        tick();
        flush_in = 1'b0; req_valid = '0;
        n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL flush_pend got %0d exp 0", pending_cnt); end
        n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", cdb_valid); end
        tick();
        n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got %b exp 0", cdb_valid); end
        req_valid = 4'b1001; set_req(0, 5'd20, 32'd20); set_req(3, 5'd21, 32'd21);
        tick();
        req_valid = '0;
        n_vec++; if (pending_cnt !== 3'd2) begin n_err++; $display("FAIL flush_reload got %0d exp 2", pending_cnt); end
        tick();
        n_vec++; if (cdb_src !== 2'd0 || cdb_rob !== 5'd20) begin n_err++; $display("FAIL flush_rrptr got src %0d rob %0d exp 0 20", cdb_src, cdb_rob); end
        tick();
        n_vec++; if (cdb_src !== 2'd3 || cdb_rob !== 5'd21) begin n_err++; $display("FAIL flush_next got src %0d rob %0d exp 3 21", cdb_src, cdb_rob); end
    endtask

    task automatic test_tag0();
        do_reset();
        req_valid = 4'b0010; set_req(1, 5'd0, 32'h1234);
        #1;
        n_vec++; if (req_ready[1] !== 1'b1) begin n_err++; $display("FAIL tag0_ready got %b exp 1", req_ready[1]); end
        tick();
        req_valid = '0;
        n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL tag0_pend got %0d exp 0", pending_cnt); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL tag0_bcast k=%0d got %b exp 0", k, cdb_valid); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0001; set_req(0, 5'd4, 32'h44);
        tick();
        req_valid = '0;
        tick();
        n_vec++; if (cdb_valid !== 1'b1 || cdb_rob !== 5'd4) begin n_err++; $display("FAIL arst_pre got v %b rob %0d exp 1 4", cdb_valid, cdb_rob); end
        #3;
        rst_in = 1'b0;
        #1;
        n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", cdb_valid); end
        n_vec++; if (cdb_rob !== 5'd0 || cdb_data !== 32'd0 || cdb_src !== 2'd0) begin n_err++; $display("FAIL arst_out got rob %0d data %h src %0d exp 0", cdb_rob, cdb_data, cdb_src); end
        req_valid = 4'b0100; set_req(2, 5'd6, 32'h66);
        rst_in = 1'b1;
        tick();
        req_valid = '0;
        n_vec++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL arst_first_hs got %0d exp 1", pending_cnt); end
        tick();
        n_vec++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_rob !== 5'd6) begin n_err++; $display("FAIL arst_after got v %b src %0d rob %0d exp 1 2 6", cdb_valid, cdb_src, cdb_rob); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_stall();
        test_flush();
        test_tag0();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
